// File: rtl/axicb_fifo_drain.sv
// Crossbar FIFO output stage: a two-entry head/skid buffer that turns the FIFO read port into a registered valid/ready stream.
// fifo_pull is computed only from the buffer level and srst/flush, so m_ready has no combinational path to the FIFO.
module axicb_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pull,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            level,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  beat_ovf
);

  localparam logic [1:0] L_EMPTY = 2'd0;
  localparam logic [1:0] L_ONE   = 2'd1;
  localparam logic [1:0] L_TWO   = 2'd2;

  logic [1:0]            r_lvl;
  logic [1:0]            w_lvl_nxt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_ovf;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_head_ld;
  logic                  w_head_from_skid;
  logic                  w_skid_ld;

  assign w_accept = fifo_pull & ~fifo_empty;
  assign w_pop    = m_valid & m_ready;

  always_ff @(posedge aclk) begin
    if (srst) r_lvl <= L_EMPTY;
    else      r_lvl <= w_lvl_nxt;
  end

  always_comb begin
    w_lvl_nxt        = r_lvl;
    w_head_ld        = 1'b0;
    w_head_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    case (r_lvl)
      L_EMPTY: begin
        if (w_accept) begin
          w_lvl_nxt = L_ONE;
          w_head_ld = 1'b1;
        end
      end
      L_ONE: begin
        if (w_accept && w_pop) begin
          w_head_ld = 1'b1;
        end else if (w_accept) begin
          w_lvl_nxt = L_TWO;
          w_skid_ld = 1'b1;
        end else if (w_pop) begin
          w_lvl_nxt = L_EMPTY;
        end
      end
      L_TWO: begin
        if (w_pop) begin
          w_lvl_nxt        = L_ONE;
          w_head_ld        = 1'b1;
          w_head_from_skid = 1'b1;
        end
      end
      default: w_lvl_nxt = L_EMPTY;
    endcase
    // flush overrides any buffer movement; the beat counter still sees the pop
    if (flush) begin
      w_lvl_nxt        = L_EMPTY;
      w_head_ld        = 1'b0;
      w_head_from_skid = 1'b0;
      w_skid_ld        = 1'b0;
    end
  end

  always_comb begin
    fifo_pull = ~srst & ~flush & (r_lvl != L_TWO);
    m_valid   = (r_lvl != L_EMPTY);
    level     = r_lvl;
  end

  always_ff @(posedge aclk) begin
    if (srst || flush) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_head_ld) r_head <= w_head_from_skid ? r_skid : fifo_data;
      if (w_skid_ld) r_skid <= fifo_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_pop) begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) r_ovf <= 1'b1;
    end
  end

  assign m_data     = r_head;
  assign beat_count = r_cnt;
  assign beat_ovf   = r_ovf;

endmodule

// File: tb/tb_axicb_fifo_drain.sv
// Self-checking bench for axicb_fifo_drain: a queue-based FIFO and buffer model checked every cycle,
// plus literal expectations for reset, streaming, backpressure, alternation, flush and counter wrap.
module tb_axicb_fifo_drain;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CMOD = 1 << CW;

  logic          aclk = 1'b0;
  logic          srst;
  logic          flush;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_pull;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    level;
  logic [CW-1:0] beat_count;
  logic          beat_ovf;

  axicb_fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .srst(srst), .flush(flush),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pull(fifo_pull),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .beat_count(beat_count), .beat_ovf(beat_ovf)
  );

  always #5 aclk = ~aclk;

  logic [DW-1:0] fq[$];   // upstream FIFO contents
  logic [DW-1:0] mb[$];   // model of buffered beats, front = m_data
  logic [DW-1:0] got[$];  // beats observed leaving the DUT
  logic [DW-1:0] exp_q[$];
  int cnt_m;
  bit ovf_m;
  int n_cmp;
  int n_err;
  int cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive FIFO view, compare outputs with the model, advance the model.
  task automatic step();
    bit e_pull, e_valid, acc, pop;
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? '0 : fq[0];
    #1;
    e_pull  = !srst && !flush && (mb.size() < 2);
    e_valid = (mb.size() != 0);
    chk("fifo_pull", int'(fifo_pull), int'(e_pull));
    chk("m_valid", int'(m_valid), int'(e_valid));
    chk("level", int'(level), mb.size());
    chk("beat_count", int'(beat_count), cnt_m);
    chk("beat_ovf", int'(beat_ovf), int'(ovf_m));
    if (e_valid) chk("m_data", int'(m_data), int'(mb[0]));
    if (m_valid && m_ready) got.push_back(m_data);
    acc = e_pull && (fq.size() != 0);
    pop = e_valid && m_ready;
    if (srst) begin
      mb.delete();
      cnt_m = 0;
      ovf_m = 1'b0;
    end else begin
      if (pop) begin
        void'(mb.pop_front());
        if (cnt_m == CMOD - 1) ovf_m = 1'b1;
        cnt_m = (cnt_m + 1) % CMOD;
      end
      if (flush) mb.delete();
      else if (acc) mb.push_back(fq[0]);
    end
    if (acc) void'(fq.pop_front());
    if (flush) fq.delete();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cnt_m = 0; ovf_m = 1'b0;
    srst = 1'b1; flush = 1'b0; m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) fq.push_back(DW'(i));
    fifo_empty = 1'b0; fifo_data = fq[0];
    @(posedge aclk);
    @(negedge aclk);

    // reset held two cycles with a non-empty FIFO
    step(); step();
    chk("reset_m_data", int'(m_data), 0);
    chk("reset_fifo_pull", int'(fifo_pull), 0);
    chk("reset_fifo_kept", fq.size(), 16);

    // streaming 0x01..0x10
    srst = 1'b0;
    got.delete();
    step();
    chk("stream_first_valid", int'(m_valid), 1);
    cyc = 0;
    while (got.size() < 16 && cyc < 40) begin step(); cyc++; end
    chk("stream_cycles", cyc, 16);
    chk("stream_beats", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("stream_data", int'(got[i]), i + 1);
    chk("stream_count_wrapped", int'(beat_count), 0);
    chk("stream_ovf", int'(beat_ovf), 1);

    // backpressure
    got.delete();
    for (int i = 0; i < 4; i++) fq.push_back(DW'(8'hA0 + i));
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_level", int'(level), 2);
    chk("bp_pull", int'(fifo_pull), 0);
    chk("bp_head", int'(m_data), 8'hA0);
    m_ready = 1'b1;
    cyc = 0;
    while (got.size() < 4 && cyc < 20) begin step(); cyc++; end
    chk("bp_cycles", cyc, 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_data", int'(got[i]), 8'hA0 + i);

    // alternating ready
    got.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      fq.push_back(DW'($urandom));
      exp_q.push_back(fq[fq.size()-1]);
    end
    cyc = 0;
    while (got.size() < 8 && cyc < 60) begin
      m_ready = (cyc % 2 == 0);
      step();
      cyc++;
    end
    chk("alt_beats", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("alt_data", int'(got[i]), int'(exp_q[i]));

    // flush with two beats held
    got.delete();
    m_ready = 1'b0;
    fq.push_back(8'h55); fq.push_back(8'h66);
    for (int i = 0; i < 3; i++) step();
    chk("flush_pre_level", int'(level), 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", int'(m_valid), 0);
    chk("flush_level", int'(level), 0);
    fq.push_back(8'h77);
    m_ready = 1'b1;
    cyc = 0;
    while (got.size() < 1 && cyc < 10) begin step(); cyc++; end
    chk("flush_next_beats", got.size(), 1);
    if (got.size() > 0) chk("flush_next_data", int'(got[0]), 8'h77);

    // counter wrap after a fresh reset
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("wrap_start_count", int'(beat_count), 0);
    chk("wrap_start_ovf", int'(beat_ovf), 0);
    got.delete();
    for (int i = 0; i < 17; i++) fq.push_back(DW'($urandom));
    cyc = 0;
    while (got.size() < 17 && cyc < 60) begin step(); cyc++; end
    chk("wrap_pops", got.size(), 17);
    chk("wrap_count", int'(beat_count), 1);
    chk("wrap_ovf", int'(beat_ovf), 1);
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("wrap_rst_count", int'(beat_count), 0);
    chk("wrap_rst_ovf", int'(beat_ovf), 0);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 8) fq.push_back(DW'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 49) == 0);
      srst    = ($urandom_range(0, 199) == 0);
      step();
    end
    srst = 1'b0; flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
